// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC / pipeline-control arbiter with EPC, kernel-mode and mul/div stall.
// Define PC_ALIGN_CHECK_EN to trap misaligned branch/jump/eret targets and add the misalign port.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h00400000,
    parameter logic [31:0] EXC_VECTOR    = 32'h80000180,
    parameter logic [31:0] IRQ_VECTOR    = 32'h80000180,
    parameter int          MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        exception,
    input  logic [31:0] exc_pc,
    input  logic        irq,
    input  logic        eret,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        load_use,
    input  logic        muldiv_start,
    output logic [31:0] pc_next,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [31:0] epc,
    output logic        kernel_mode,
    output logic        md_busy
`ifdef PC_ALIGN_CHECK_EN
   ,output logic        misalign
`endif
);
    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] epc_n, tgt, trap_epc;
    logic        km_n, trap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= 4'd0;
            epc         <= RESET_PC;
            kernel_mode <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            epc         <= epc_n;
            kernel_mode <= km_n;
        end
    end

    // Branch (EX) beats eret/jump (ID); all three share one redirect path.
    assign tgt = branch_taken ? branch_target : eret ? epc : jump_target;

    always_comb begin
        pc_next     = pc_cur + 32'd4;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_busy     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        misalign    = 1'b0;
`endif
        state_n     = state;
        cnt_n       = cnt;
        epc_n       = epc;
        km_n        = kernel_mode;
        trap        = 1'b0;
        trap_epc    = exc_pc;
        if (state == MD_WAIT) begin
            md_busy = 1'b1;
            if (exception) begin
                trap    = 1'b1;
                state_n = RUN;
                cnt_n   = 4'd0;
            end else begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                cnt_n       = cnt - 4'd1;
                state_n     = (cnt == 4'd1) ? RUN : MD_WAIT;
            end
        end else if (exception) begin
            trap = 1'b1;
        end else if (irq && !kernel_mode) begin
            pc_next     = IRQ_VECTOR;
            if_id_flush = 1'b1;
            epc_n       = pc_cur;
            km_n        = 1'b1;
        end else if (branch_taken || eret || jump) begin
`ifdef PC_ALIGN_CHECK_EN
            if (|tgt[1:0]) begin
                trap     = 1'b1;
                trap_epc = pc_cur;
                misalign = 1'b1;
            end else
`endif
            begin
                pc_next     = tgt;
                if_id_flush = 1'b1;
                id_ex_flush = branch_taken;
                km_n        = (eret && !branch_taken) ? 1'b0 : kernel_mode;
            end
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (muldiv_start) begin
            state_n = MD_WAIT;
            cnt_n   = 4'(MULDIV_CYCLES - 1);
        end
        if (trap) begin
            pc_next     = EXC_VECTOR;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            epc_n       = trap_epc;
            km_n        = 1'b1;
        end
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            md_busy     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign    = 1'b0;
`endif
        end
    end
endmodule
